// File: rtl/heightmap_pkg.sv
// Shared types and constants for the heightmap pixel writer and its colour map.
package heightmap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_CAPTURE,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [7:0] RGB_SAND = 8'hF6;
    localparam logic [7:0] RGB_SNOW = 8'hFF;

    // Upper (exclusive) height bounds of the water, sand and grass bands
    localparam logic [7:0] Z_WATER_LIMIT = 8'd64;
    localparam logic [7:0] Z_SAND_LIMIT  = 8'd96;
    localparam logic [7:0] Z_GRASS_LIMIT = 8'd192;

    localparam int DEFAULT_FB_WIDTH = 640;

endpackage

// File: rtl/height_colormap.sv
// Pure combinational height -> RGB332 map, no state and no backpressure.
// HEIGHTMAP_COLORMAP_EN selects the terrain palette; otherwise greyscale.
module height_colormap
    import heightmap_pkg::*;
(
    input  logic [7:0] z,
    output logic [7:0] rgb
);

`ifdef HEIGHTMAP_COLORMAP_EN
    logic unused_z;
    assign unused_z = ^z[2:0];

    always_comb begin
        rgb = RGB_SNOW;
        if (z < Z_WATER_LIMIT) begin
            // Blue in the low bits, green carries the shallow-water shade
            rgb = {3'd0, 1'b0, z[5:4], 2'd3};
        end else if (z < Z_SAND_LIMIT) begin
            rgb = RGB_SAND;
        end else if (z < Z_GRASS_LIMIT) begin
            rgb = {3'd0, z[7:5], 2'd0};
        end
    end
`else
    logic unused_z;
    assign unused_z = ^z[4:0];

    assign rgb = {z[7:5], z[7:5], z[7:6]};
`endif

endmodule

// File: rtl/heightmap_pixel_writer.sv
// Reads DIM*DIM generator points via ack/capture and paints each as a 2^SCALE_LOG2 square of
// RGB332 pixels over an Avalon-MM write master; beats hold under m_waitrequest. Palette: HEIGHTMAP_COLORMAP_EN.
module heightmap_pixel_writer
    import heightmap_pkg::*;
#(
    parameter int          DIM           = 9,
    parameter int          SCALE_LOG2    = 2,
    parameter int          CAPTURE_DELAY = 3,
    parameter logic [31:0] FB_BASE       = 32'h0000_0000,
    parameter int          FB_WIDTH      = DEFAULT_FB_WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        gen_done,
    input  logic [9:0]  gen_x,
    input  logic [9:0]  gen_y,
    input  logic [7:0]  gen_z,
    output logic        gen_ack,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [7:0]  m_writedata,
    input  logic        m_waitrequest,
    output logic        frame_done
);

    localparam int NPTS  = DIM * DIM;
    localparam int CNT_W = ($clog2(NPTS) > 0) ? $clog2(NPTS) : 1;
    localparam int DLY_W = ($clog2(CAPTURE_DELAY + 1) > 0) ? $clog2(CAPTURE_DELAY + 1) : 1;
    localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [CNT_W-1:0] LAST_PT  = CNT_W'(NPTS - 1);
    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(CAPTURE_DELAY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pt_q, pt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [SUB_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [7:0]       col_q, col_d;
    logic [7:0]       cur_rgb;
    logic [31:0]      px, py;

    height_colormap u_colormap (
        .z   (gen_z),
        .rgb (cur_rgb)
    );

    // Address is a pure function of captured point and sub-pixel offset, so it is stable under stalls
    assign px          = (32'(x_q) << SCALE_LOG2) + 32'(dx_q);
    assign py          = (32'(y_q) << SCALE_LOG2) + 32'(dy_q);
    assign m_address   = FB_BASE + py * 32'(FB_WIDTH) + px;
    assign m_writedata = col_q;
    assign frame_done  = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        pt_d    = pt_q;
        dly_d   = dly_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        gen_ack = 1'b0;
        m_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gen_done) state_d = ST_ACK;
            end
            ST_ACK: begin
                gen_ack = 1'b1;
                dly_d   = DLY_LOAD;
                state_d = (CAPTURE_DELAY <= 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                // Leave when the counter reaches zero so the capture lands CAPTURE_DELAY cycles after ack
                dly_d = dly_q - 1'b1;
                if (dly_q <= DLY_W'(1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                x_d     = gen_x;
                y_d     = gen_y;
                col_d   = cur_rgb;
                dx_d    = '0;
                dy_d    = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                m_write = 1'b1;
                if (!m_waitrequest) begin
                    if (dx_q == SUB_MAX) begin
                        dx_d = '0;
                        if (dy_q == SUB_MAX) state_d = ST_NEXT;
                        else                 dy_d = dy_q + 1'b1;
                    end else begin
                        dx_d = dx_q + 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (pt_q == LAST_PT) begin
                    state_d = ST_DONE;
                end else begin
                    pt_d    = pt_q + 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pt_q    <= '0;
            dly_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            dly_q   <= dly_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_heightmap_pixel_writer.sv
// Bench for heightmap_pixel_writer: generator and Avalon slave models with a frame-level reference.
module tb_heightmap_pixel_writer;

    localparam int          DIM   = 3;
    localparam int          S     = 2;
    localparam int          DLY   = 3;
    localparam int          W     = 640;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          NPTS  = DIM * DIM;
    localparam int          EDGE  = 1 << S;
    localparam int          BEATS = EDGE * EDGE;

    logic        clock = 1'b0;
    logic        reset;
    logic        gen_done;
    logic [9:0]  gen_x, gen_y;
    logic [7:0]  gen_z;
    logic        gen_ack;
    logic [31:0] m_address;
    logic        m_write;
    logic [7:0]  m_writedata;
    logic        m_waitrequest;
    logic        frame_done;

    always #5 clock = ~clock;

    heightmap_pixel_writer #(
        .DIM           (DIM),
        .SCALE_LOG2    (S),
        .CAPTURE_DELAY (DLY),
        .FB_BASE       (BASE),
        .FB_WIDTH      (W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .gen_done      (gen_done),
        .gen_x         (gen_x),
        .gen_y         (gen_y),
        .gen_z         (gen_z),
        .gen_ack       (gen_ack),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .frame_done    (frame_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Written only by the directed sequence
    int z_tab [NPTS];
    int wait_pct = 0;
    int stall_at = -1;

    // Written only by the bus model
    int          gen_p = 0, gen_cur = 0, gen_pend = 0;
    int          ack_cnt = 0, ack_double = 0, stall_seen = 0, stable_bad = 0;
    logic        prev_ack = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic [31:0] wa [$];
    logic [7:0]  wd [$];

    // Generator: column-major point order, sample valid DLY cycles after the ack cycle, held until next ack.
    // Slave: optional forced stall on one beat plus random waitrequest; records every accepted beat.
    always @(negedge clock) begin
        if (reset) begin
            gen_p    = 0;
            gen_pend = 0;
        end
        if (!reset && gen_ack) begin
            ack_cnt++;
            if (prev_ack) ack_double++;
            gen_cur  = gen_p % NPTS;
            gen_p++;
            gen_pend = DLY;
            gen_x    = 10'($urandom);
            gen_y    = 10'($urandom);
            gen_z    = 8'($urandom);
        end else if (gen_pend > 0) begin
            gen_pend--;
            if (gen_pend == 0) begin
                gen_x = 10'(gen_cur / DIM);
                gen_y = 10'(gen_cur % DIM);
                gen_z = 8'(z_tab[gen_cur]);
            end else begin
                gen_x = 10'($urandom);
                gen_y = 10'($urandom);
                gen_z = 8'($urandom);
            end
        end
        prev_ack = gen_ack;

        if (m_write && wa.size() == stall_at && stall_seen < 5) begin
            m_waitrequest = 1'b1;
            stall_seen++;
        end else begin
            m_waitrequest = ($urandom_range(0, 99) < wait_pct);
        end

        if (prev_stall && !reset) begin
            if (m_write !== 1'b1 || m_address !== prev_addr || m_writedata !== prev_data)
                stable_bad++;
        end
        if (m_write && !m_waitrequest && !reset) begin
            wa.push_back(m_address);
            wd.push_back(m_writedata);
        end
        prev_stall = m_write && m_waitrequest;
        prev_addr  = m_address;
        prev_data  = m_writedata;
    end

    function automatic logic [7:0] ref_colour(input int z);
`ifdef HEIGHTMAP_COLORMAP_EN
        if (z < 64)  return 8'((((z / 8) % 8) / 2) * 4 + 3);
        if (z < 96)  return 8'd246;
        if (z < 192) return 8'((z / 32) * 4);
        return 8'd255;
`else
        return 8'((z / 32) * 32 + (z / 32) * 4 + z / 64);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input int wbase, input int abase);
        int cyc = 0;
        int k   = 0;
        while (!frame_done && cyc < 4000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " frame_done"}, 32'(frame_done), 32'd1);
        check({tag, " ack count"}, 32'(ack_cnt - abase), 32'(NPTS));
        check({tag, " write count at done"}, 32'(wa.size() - wbase), 32'(NPTS * BEATS));
        for (int p = 0; p < NPTS; p++) begin
            for (int dy = 0; dy < EDGE; dy++) begin
                for (int dx = 0; dx < EDGE; dx++) begin
                    int          i;
                    logic [31:0] ea;
                    i  = wbase + k;
                    ea = BASE + 32'(((p % DIM) * EDGE + dy) * W + (p / DIM) * EDGE + dx);
                    if (i < wa.size()) begin
                        check($sformatf("%s p%0d beat%0d addr", tag, p, k % BEATS), wa[i], ea);
                        check($sformatf("%s p%0d beat%0d data", tag, p, k % BEATS),
                              32'(wd[i]), 32'(ref_colour(z_tab[p])));
                    end
                    k++;
                end
            end
        end
    endtask

    initial begin
        int a0, w0, cyc;
        logic found;

        reset    = 1'b1;
        gen_done = 1'b0;
        // Frame 1 heights exercise every palette boundary; p3=(1,0) z=0 and p7=(2,1) z=200
        z_tab = '{63, 64, 191, 0, 192, 95, 96, 200, 255};
        tick(3);
        check("reset gen_ack", 32'(gen_ack), 32'd0);
        check("reset m_write", 32'(m_write), 32'd0);
        check("reset m_address", m_address, BASE);
        check("reset m_writedata", 32'(m_writedata), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);

        reset = 1'b0;
        a0 = ack_cnt;
        w0 = wa.size();
        tick(100);
        check("idle acks without gen_done", 32'(ack_cnt - a0), 32'd0);
        check("idle writes without gen_done", 32'(wa.size() - w0), 32'd0);

        stall_at = w0 + 2;
        gen_done = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < 2 && !found; c++) begin
            @(negedge clock);
            if (gen_ack) found = 1'b1;
        end
        check("first ack within 2 cycles", 32'(found), 32'd1);

        cyc = 0;
        while (ack_cnt - a0 < 2 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        gen_done = 1'b0;
        check_frame("frame1", w0, a0);
        check("frame1 forced stall cycles", 32'(stall_seen), 32'd5);
        check("stall stability violations", 32'(stable_bad), 32'd0);
        check("ack pulses longer than one cycle", 32'(ack_double), 32'd0);

        a0 = ack_cnt;
        w0 = wa.size();
        tick(20);
        check("done sticky frame_done", 32'(frame_done), 32'd1);
        check("done no extra acks", 32'(ack_cnt - a0), 32'd0);
        check("done no extra writes", 32'(wa.size() - w0), 32'd0);
        check("done m_write low", 32'(m_write), 32'd0);

        reset    = 1'b1;
        gen_done = 1'b1;
        wait_pct = 30;
        for (int p = 0; p < NPTS; p++) z_tab[p] = $urandom_range(0, 255);
        tick(2);
        reset = 1'b0;
        a0    = ack_cnt;
        cyc   = 0;
        while (!(ack_cnt - a0 == 5 && m_write) && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check("reached write of point 4", 32'(ack_cnt - a0), 32'd5);
        check("m_write high before abort", 32'(m_write), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort m_write dropped", 32'(m_write), 32'd0);
        check("abort frame_done low", 32'(frame_done), 32'd0);
        check("abort gen_ack low", 32'(gen_ack), 32'd0);
        tick(2);

        wait_pct = 50;
        for (int p = 0; p < NPTS; p++) z_tab[p] = $urandom_range(0, 255);
        a0    = ack_cnt;
        w0    = wa.size();
        reset = 1'b0;
        check_frame("frame3", w0, a0);
        check("stall stability after restart", 32'(stable_bad), 32'd0);
        check("ack pulses after restart", 32'(ack_double), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
